// File: rtl/inst_cache_dm.sv
// Direct-mapped, read-only instruction cache between the CPU fetch port and the
// sram-like instruction port of the AXI bridge.
//   cpu_inst_*  : fetch request/accept, one-cycle data_ok pulse with instruction
//   mem_inst_*  : single-word downstream reads (line refill or kseg1 uncached read)
// Hits answer one cycle after accept. A miss refills the whole line word 0 first,
// one outstanding read at a time. kseg1 addresses bypass the arrays entirely.
module inst_cache_dm #(
  parameter int unsigned INDEX_WIDTH  = 6,
  parameter int unsigned OFFSET_WIDTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_inst_req,
  input  logic [31:0] cpu_inst_addr,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  output logic [31:0] cpu_inst_rdata,
  output logic        mem_inst_req,
  output logic        mem_inst_wr,
  output logic [1:0]  mem_inst_size,
  output logic [31:0] mem_inst_addr,
  output logic [31:0] mem_inst_wdata,
  input  logic        mem_inst_addr_ok,
  input  logic        mem_inst_data_ok,
  input  logic [31:0] mem_inst_rdata
);

  localparam int unsigned TagWidth = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int unsigned CntWidth = OFFSET_WIDTH - 2;
  localparam int unsigned Lines    = 1 << INDEX_WIDTH;
  localparam int unsigned Words    = 1 << CntWidth;
  localparam logic [CntWidth-1:0] LastWord = CntWidth'(Words - 1);

  typedef enum logic [2:0] {
    StIdle, StLookup, StRefillReq, StRefillWait, StUncReq, StUncWait, StResp
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            addr_q;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [Lines-1:0]       valid_q;
  logic [Words-1:0][31:0] lbuf_q;
  logic [Words-1:0][31:0] line_fill;

  logic [TagWidth-1:0]    tag_arr  [Lines];
  logic [Words-1:0][31:0] data_arr [Lines];

  logic [TagWidth-1:0]    req_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [CntWidth-1:0]    req_word;
  logic                   uncached, hit, accept, word_done, line_done;

  assign req_tag   = addr_q[31 -: TagWidth];
  assign req_index = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_word  = addr_q[2 +: CntWidth];
  assign uncached  = (addr_q[31:29] == 3'b101);
  assign hit       = valid_q[req_index] && (tag_arr[req_index] == req_tag);
  assign accept    = (state_q == StIdle) && cpu_inst_req;
  assign word_done = (state_q == StRefillWait) && mem_inst_data_ok;
  assign line_done = word_done && (cnt_q == LastWord);

  assign mem_inst_wr    = 1'b0;
  assign mem_inst_size  = 2'b10;
  assign mem_inst_wdata = 32'h0;

  // The last word is still on the bus when the line is committed, so merge it in.
  always_comb begin
    line_fill        = lbuf_q;
    line_fill[cnt_q] = mem_inst_rdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      addr_q  <= 32'h0;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) addr_q <= cpu_inst_addr;
      if (line_done) valid_q[req_index] <= 1'b1;
    end
  end

  // Arrays and the line buffer are deliberately left unreset; valid_q guards them.
  always_ff @(posedge clk) begin
    if (word_done) lbuf_q[cnt_q] <= mem_inst_rdata;
    if (line_done) begin
      tag_arr[req_index]  <= req_tag;
      data_arr[req_index] <= line_fill;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle:       if (cpu_inst_req) state_d = StLookup;
      StLookup: begin
        if (uncached) begin
          state_d = StUncReq;
        end else if (hit) begin
          state_d = StIdle;
        end else begin
          state_d = StRefillReq;
          cnt_d   = '0;
        end
      end
      StRefillReq:  if (mem_inst_addr_ok) state_d = StRefillWait;
      StRefillWait: begin
        if (mem_inst_data_ok) begin
          if (cnt_q == LastWord) begin
            state_d = StResp;
          end else begin
            state_d = StRefillReq;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      StUncReq:     if (mem_inst_addr_ok) state_d = StUncWait;
      StUncWait:    if (mem_inst_data_ok) state_d = StIdle;
      StResp:       state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_comb begin
    cpu_inst_addr_ok = 1'b0;
    cpu_inst_data_ok = 1'b0;
    cpu_inst_rdata   = 32'h0;
    mem_inst_req     = 1'b0;
    mem_inst_addr    = 32'h0;
    unique case (state_q)
      StIdle:   cpu_inst_addr_ok = cpu_inst_req;
      StLookup: begin
        if (!uncached && hit) begin
          cpu_inst_data_ok = 1'b1;
          cpu_inst_rdata   = data_arr[req_index][req_word];
        end
      end
      StRefillReq: begin
        mem_inst_req  = 1'b1;
        mem_inst_addr = {req_tag, req_index, cnt_q, 2'b00};
      end
      StUncReq: begin
        mem_inst_req  = 1'b1;
        mem_inst_addr = addr_q;
      end
      StUncWait: begin
        if (mem_inst_data_ok) begin
          cpu_inst_data_ok = 1'b1;
          cpu_inst_rdata   = mem_inst_rdata;
        end
      end
      StResp: begin
        cpu_inst_data_ok = 1'b1;
        cpu_inst_rdata   = lbuf_q[req_word];
      end
      default: ;
    endcase
  end

endmodule
